// File: rtl/seq_cmd_decoder.sv
// Byte-stream command decoder feeding the sequence waveform generator.
// Frames SYNC/OPCODE/PAYLOAD/CHK, then holds mode and strobes ready flags for a fixed window.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// HUNT     | waiting for SYNC_BYTE, other bytes dropped silently
// OPCODE   | expecting opcode byte
// PAYLOAD  | shifting payload bytes into holding register
// CHK      | expecting checksum byte
// EXEC     | frame accepted, mode and data registered this cycle
// STROBE   | flags high for STROBE_LEN cycles, then one flag-low hold cycle
module seq_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         STROBE_LEN   = 4,
  parameter int         TIMEOUT      = 50000,
  parameter logic [7:0] M_IDLE       = 8'h00,
  parameter logic [7:0] M_CMD_ARM    = 8'h01,
  parameter logic [7:0] M_SET_PERIOD = 8'h02,
  parameter logic [7:0] M_LOAD       = 8'h03,
  parameter logic [7:0] M_STOP       = 8'h04
) (
  input  logic        iCLK,
  input  logic        iNRST,
  input  logic [7:0]  iRX_DATA,
  input  logic        iRX_VALID,
  output logic [7:0]  oCTRL_MODE,
  output logic        oFLAG_TIME_READY,
  output logic        oFLAG_CH_VAL_READY,
  output logic [7:0]  oDATA_CHANNEL,
  output logic [47:0] oDATA_TIME,
  output logic        oDATA_CH_VAL,
  output logic        oBUSY,
  output logic        oERR_PULSE,
  output logic [2:0]  oERR_CODE,
  output logic [7:0]  oERR_COUNT
);

  localparam logic [7:0]  OP_ARM   = 8'h01;
  localparam logic [7:0]  OP_SET   = 8'h02;
  localparam logic [7:0]  OP_LOAD  = 8'h03;
  localparam logic [7:0]  OP_STOP  = 8'h04;
  localparam logic [2:0]  ERR_CHK  = 3'd1;
  localparam logic [2:0]  ERR_OP   = 3'd2;
  localparam logic [2:0]  ERR_OVR  = 3'd3;
  localparam logic [2:0]  ERR_TO   = 3'd4;
  localparam logic [3:0]  STB_LOAD = 4'(STROBE_LEN);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_HUNT, S_OPCODE, S_PAYLOAD, S_CHK, S_EXEC, S_STROBE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_op;
  logic [7:0]   r_chk;
  logic [63:0]  r_shift;
  logic [3:0]   r_pay_cnt;
  logic [15:0]  r_to_cnt;
  logic [3:0]   r_stb_cnt;
  logic         w_err;
  logic [2:0]   w_err_code;
  logic         w_frame_ok;
  logic         w_timeout;
  logic         w_in_frame;

  assign w_in_frame = (r_state == S_OPCODE) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // A byte landing in the terminal-count cycle wins over the timeout.
  assign w_timeout  = (r_to_cnt == TO_LIMIT) && !iRX_VALID;
  assign oBUSY      = (r_state != S_HUNT);

  always_ff @(posedge iCLK or negedge iNRST) begin
    if (!iNRST) r_state <= S_HUNT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_err_code = 3'd0;
    w_frame_ok = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (iRX_VALID && (iRX_DATA == SYNC_BYTE)) w_next = S_OPCODE;
      end
      S_OPCODE: begin
        if (iRX_VALID) begin
          if ((iRX_DATA == OP_ARM) || (iRX_DATA == OP_STOP)) begin
            w_next = S_CHK;
          end else if ((iRX_DATA == OP_SET) || (iRX_DATA == OP_LOAD)) begin
            w_next = S_PAYLOAD;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_OP;
            w_next     = S_HUNT;
          end
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_err_code = ERR_TO;
          w_next     = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (iRX_VALID) begin
          if (r_pay_cnt == 4'd1) w_next = S_CHK;
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_err_code = ERR_TO;
          w_next     = S_HUNT;
        end
      end
      S_CHK: begin
        if (iRX_VALID) begin
          if (iRX_DATA == r_chk) begin
            w_frame_ok = 1'b1;
            w_next     = S_EXEC;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_CHK;
            w_next     = S_HUNT;
          end
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_err_code = ERR_TO;
          w_next     = S_HUNT;
        end
      end
      S_EXEC: begin
        w_next = S_STROBE;
        if (iRX_VALID) begin
          w_err      = 1'b1;
          w_err_code = ERR_OVR;
        end
      end
      S_STROBE: begin
        if (r_stb_cnt == 4'd0) w_next = S_HUNT;
        if (iRX_VALID) begin
          w_err      = 1'b1;
          w_err_code = ERR_OVR;
        end
      end
      default: w_next = S_HUNT;
    endcase
  end

  always_ff @(posedge iCLK or negedge iNRST) begin
    if (!iNRST) begin
      r_op               <= '0;
      r_chk              <= '0;
      r_shift            <= '0;
      r_pay_cnt          <= '0;
      r_to_cnt           <= '0;
      r_stb_cnt          <= '0;
      oCTRL_MODE         <= M_IDLE;
      oFLAG_TIME_READY   <= 1'b0;
      oFLAG_CH_VAL_READY <= 1'b0;
      oDATA_CHANNEL      <= '0;
      oDATA_TIME         <= '0;
      oDATA_CH_VAL       <= 1'b0;
      oERR_PULSE         <= 1'b0;
      oERR_CODE          <= '0;
      oERR_COUNT         <= '0;
    end else begin
      if (w_in_frame && !iRX_VALID && (w_next == r_state)) r_to_cnt <= r_to_cnt + 16'd1;
      else                                                  r_to_cnt <= '0;

      case (r_state)
        S_HUNT: r_chk <= '0;
        S_OPCODE: begin
          if (iRX_VALID) begin
            r_op      <= iRX_DATA;
            r_chk     <= iRX_DATA;
            r_pay_cnt <= (iRX_DATA == OP_SET) ? 4'd6 : 4'd8;
          end
        end
        S_PAYLOAD: begin
          if (iRX_VALID) begin
            r_chk     <= r_chk ^ iRX_DATA;
            r_shift   <= {r_shift[55:0], iRX_DATA};
            r_pay_cnt <= r_pay_cnt - 4'd1;
          end
        end
        S_EXEC: begin
          r_stb_cnt          <= STB_LOAD;
          oFLAG_TIME_READY   <= (r_op == OP_SET) || (r_op == OP_LOAD);
          oFLAG_CH_VAL_READY <= (r_op == OP_LOAD);
        end
        S_STROBE: begin
          if (r_stb_cnt != 4'd0) begin
            r_stb_cnt <= r_stb_cnt - 4'd1;
            if (r_stb_cnt == 4'd1) begin
              oFLAG_TIME_READY   <= 1'b0;
              oFLAG_CH_VAL_READY <= 1'b0;
            end
          end else begin
            oCTRL_MODE <= M_IDLE;
          end
        end
        default: ;
      endcase

      // LOAD payload: channel, 6 time bytes MSB first, value byte (bit0 only).
      if (w_frame_ok) begin
        case (r_op)
          OP_ARM:  oCTRL_MODE <= M_CMD_ARM;
          OP_STOP: oCTRL_MODE <= M_STOP;
          OP_SET: begin
            oCTRL_MODE <= M_SET_PERIOD;
            oDATA_TIME <= r_shift[47:0];
          end
          OP_LOAD: begin
            oCTRL_MODE    <= M_LOAD;
            oDATA_CHANNEL <= r_shift[63:56];
            oDATA_TIME    <= r_shift[55:8];
            oDATA_CH_VAL  <= r_shift[0];
          end
          default: oCTRL_MODE <= M_IDLE;
        endcase
      end

      oERR_PULSE <= w_err;
      if (w_err) begin
        oERR_CODE <= w_err_code;
        if (oERR_COUNT != 8'hFF) oERR_COUNT <= oERR_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_cmd_decoder.sv
// Scoreboard bench for seq_cmd_decoder: expected commands/errors queued at stimulus time,
// popped by a monitor when the DUT raises a mode window or an error pulse.
module tb_seq_cmd_decoder;

  localparam int L  = 4;
  localparam int TO = 200;

  logic        iCLK = 1'b0;
  logic        iNRST;
  logic [7:0]  iRX_DATA;
  logic        iRX_VALID;
  logic [7:0]  oCTRL_MODE;
  logic        oFLAG_TIME_READY;
  logic        oFLAG_CH_VAL_READY;
  logic [7:0]  oDATA_CHANNEL;
  logic [47:0] oDATA_TIME;
  logic        oDATA_CH_VAL;
  logic        oBUSY;
  logic        oERR_PULSE;
  logic [2:0]  oERR_CODE;
  logic [7:0]  oERR_COUNT;

  seq_cmd_decoder #(.STROBE_LEN(L), .TIMEOUT(TO)) u_dut (
    .iCLK               (iCLK),
    .iNRST              (iNRST),
    .iRX_DATA           (iRX_DATA),
    .iRX_VALID          (iRX_VALID),
    .oCTRL_MODE         (oCTRL_MODE),
    .oFLAG_TIME_READY   (oFLAG_TIME_READY),
    .oFLAG_CH_VAL_READY (oFLAG_CH_VAL_READY),
    .oDATA_CHANNEL      (oDATA_CHANNEL),
    .oDATA_TIME         (oDATA_TIME),
    .oDATA_CH_VAL       (oDATA_CH_VAL),
    .oBUSY              (oBUSY),
    .oERR_PULSE         (oERR_PULSE),
    .oERR_CODE          (oERR_CODE),
    .oERR_COUNT         (oERR_COUNT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [7:0]  cnt;
    logic [7:0]  mode;
    logic [7:0]  ch;
    logic [47:0] tm;
    logic        v;
    bit          has_t;
    bit          has_c;
  } ev_t;

  ev_t         sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          exp_err_cnt;
  logic [7:0]  exp_ch;
  logic [47:0] exp_tm;
  logic        exp_v;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [7:0] mode, input bit has_t, input bit has_c);
    ev_t e;
    e.is_err = 1'b0; e.code = '0; e.cnt = '0;
    e.mode = mode; e.ch = exp_ch; e.tm = exp_tm; e.v = exp_v;
    e.has_t = has_t; e.has_c = has_c;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] code);
    ev_t e;
    if (exp_err_cnt < 255) exp_err_cnt++;
    e.is_err = 1'b1; e.code = code; e.cnt = 8'(exp_err_cnt);
    e.mode = '0; e.ch = '0; e.tm = '0; e.v = 1'b0; e.has_t = 1'b0; e.has_c = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge iCLK);
    #1;
    iRX_DATA  = b;
    iRX_VALID = 1'b1;
    @(posedge iCLK);
    #1;
    iRX_VALID = 1'b0;
  endtask

  // payload is left-aligned in pl; n bytes sent MSB first
  task automatic send_frame(input logic [7:0] op, input logic [63:0] pl, input int n, input bit bad);
    logic [7:0] chk;
    logic [7:0] b;
    chk = op;
    send_byte(8'hA5);
    send_byte(op);
    for (int i = 0; i < n; i++) begin
      b = pl[63-8*i -: 8];
      chk = chk ^ b;
      send_byte(b);
    end
    send_byte(bad ? (chk ^ 8'h5A) : chk);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge iCLK);
      if (!oBUSY) done = 1'b1;
    end
    check_val("idle_wait", 64'(done), 1);
  endtask

  // monitor
  bit         win_active = 1'b0;
  int         win_k;
  int         shape_bad;
  ev_t        cur;
  ev_t        mon_e;
  logic [7:0] prev_mode = 8'h00;
  logic       ef_t, ef_c;
  logic [7:0] ef_m;

  always @(negedge iCLK) begin
    if (!iNRST) begin
      win_active = 1'b0;
      prev_mode  = 8'h00;
    end else begin
      if (oERR_PULSE) begin
        if (sb_q.size() == 0) begin
          check_val("err_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("err_kind", 64'(mon_e.is_err), 1);
          check_val("err_code", 64'(oERR_CODE), 64'(mon_e.code));
          check_val("err_count", 64'(oERR_COUNT), 64'(mon_e.cnt));
        end
      end
      if (!win_active && (oCTRL_MODE != 8'h00) && (prev_mode == 8'h00)) begin
        if (sb_q.size() == 0) begin
          check_val("cmd_unexpected", 1, 0);
        end else begin
          cur = sb_q.pop_front();
          check_val("cmd_kind", 64'(cur.is_err), 0);
          check_val("cmd_mode", 64'(oCTRL_MODE), 64'(cur.mode));
          check_val("cmd_channel", 64'(oDATA_CHANNEL), 64'(cur.ch));
          check_val("cmd_time", 64'(oDATA_TIME), 64'(cur.tm));
          check_val("cmd_val", 64'(oDATA_CH_VAL), 64'(cur.v));
          win_active = 1'b1;
          win_k      = 0;
          shape_bad  = 0;
        end
      end
      if (win_active) begin
        ef_t = cur.has_t && (win_k >= 1) && (win_k <= L);
        ef_c = cur.has_c && (win_k >= 1) && (win_k <= L);
        ef_m = (win_k <= L + 1) ? cur.mode : 8'h00;
        if (oFLAG_TIME_READY !== ef_t)   shape_bad++;
        if (oFLAG_CH_VAL_READY !== ef_c) shape_bad++;
        if (oCTRL_MODE !== ef_m)         shape_bad++;
        if (win_k == L + 2) begin
          check_val("strobe_shape", 64'(shape_bad), 0);
          win_active = 1'b0;
        end
        win_k++;
      end
      prev_mode = oCTRL_MODE;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    bit seen;
    iNRST = 1'b0; iRX_DATA = 8'h00; iRX_VALID = 1'b0;
    exp_err_cnt = 0; exp_ch = '0; exp_tm = '0; exp_v = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_val("rst_mode", 64'(oCTRL_MODE), 0);
    check_val("rst_flags", 64'({oFLAG_TIME_READY, oFLAG_CH_VAL_READY}), 0);
    check_val("rst_data", 64'({oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL}), 0);
    check_val("rst_err", 64'({oERR_PULSE, oERR_CODE, oERR_COUNT}), 0);
    check_val("rst_busy", 64'(oBUSY), 0);
    iNRST = 1'b1;
    repeat (2) @(posedge iCLK);

    // ARM
    push_cmd(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 64'h0, 0, 1'b0);
    wait_idle(50);
    check_val("arm_busy_after", 64'(oBUSY), 0);

    // SET_PERIOD 0x3E8
    exp_tm = 48'h3E8;
    push_cmd(8'h02, 1'b1, 1'b0);
    send_frame(8'h02, {48'h3E8, 16'h0}, 6, 1'b0);
    wait_idle(50);

    // LOAD ch7 t16 v1
    exp_ch = 8'h07; exp_tm = 48'h10; exp_v = 1'b1;
    push_cmd(8'h03, 1'b1, 1'b1);
    send_frame(8'h03, {8'h07, 48'h10, 8'h01}, 8, 1'b0);
    wait_idle(50);

    // LOAD with bad checksum leaves outputs alone
    push_err(3'd1);
    send_frame(8'h03, {8'h09, 48'h55, 8'h00}, 8, 1'b1);
    repeat (3) @(negedge iCLK);
    check_val("badchk_code", 64'(oERR_CODE), 1);
    check_val("badchk_count", 64'(oERR_COUNT), 1);
    check_val("badchk_keep", 64'({oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL}), 64'({8'h07, 48'h10, 1'b1}));

    // garbage, bad opcode, then normal ARM
    push_err(3'd2);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h09);
    repeat (3) @(negedge iCLK);
    check_val("badop_code", 64'(oERR_CODE), 2);
    check_val("badop_busy", 64'(oBUSY), 0);
    push_cmd(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 64'h0, 0, 1'b0);
    wait_idle(50);

    // opcode arrives exactly when the idle counter reaches TIMEOUT: accepted
    push_cmd(8'h01, 1'b0, 1'b0);
    send_byte(8'hA5);
    repeat (TO - 1) @(posedge iCLK);
    send_byte(8'h01);
    send_byte(8'h01);
    wait_idle(50);

    // stall inside SET_PERIOD payload -> timeout
    push_err(3'd4);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_idle(TO + 20);
    @(negedge iCLK);
    check_val("timeout_code", 64'(oERR_CODE), 4);
    check_val("timeout_busy", 64'(oBUSY), 0);

    // overrun during strobe; strobe shape still checked by monitor
    exp_tm = 48'h123456789ABC;
    push_cmd(8'h02, 1'b1, 1'b0);
    send_frame(8'h02, {48'h123456789ABC, 16'h0}, 6, 1'b0);
    push_err(3'd3);
    @(posedge iCLK);
    send_byte(8'h55);
    wait_idle(50);
    check_val("overrun_code", 64'(oERR_CODE), 3);

    // saturate error counter
    for (int i = 0; i < 260; i++) begin
      push_err(3'd2);
      send_byte(8'hA5);
      send_byte(8'hC3);
    end
    repeat (3) @(negedge iCLK);
    check_val("err_saturate", 64'(oERR_COUNT), 255);

    // reset in the middle of a LOAD strobe; value byte 0x03 uses bit0 only
    exp_ch = 8'h2A; exp_tm = 48'hABCDEF; exp_v = 1'b1;
    push_cmd(8'h03, 1'b1, 1'b1);
    send_frame(8'h03, {8'h2A, 48'hABCDEF, 8'h03}, 8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge iCLK);
      if (oFLAG_CH_VAL_READY) seen = 1'b1;
    end
    check_val("load_flag_seen", 64'(seen), 1);
    @(posedge iCLK);
    #1;
    iNRST = 1'b0;
    #1;
    check_val("midrst_mode", 64'(oCTRL_MODE), 0);
    check_val("midrst_flags", 64'({oFLAG_TIME_READY, oFLAG_CH_VAL_READY}), 0);
    check_val("midrst_data", 64'({oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL}), 0);
    check_val("midrst_err", 64'({oERR_CODE, oERR_COUNT}), 0);
    check_val("midrst_busy", 64'(oBUSY), 0);
    exp_ch = '0; exp_tm = '0; exp_v = 1'b0; exp_err_cnt = 0;
    repeat (2) @(posedge iCLK);
    #1;
    iNRST = 1'b1;

    push_cmd(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 64'h0, 0, 1'b0);
    wait_idle(50);
    repeat (2) @(negedge iCLK);
    check_val("sb_empty", 64'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
